// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch stage: sizes, reset index,
// fetch FSM encoding and the buffer entry layout.
package cpu_pkg;

  localparam int unsigned CACHE_WORDS = 1000;
  localparam logic [31:0] RESET_PC    = 32'd0;
  localparam int          INSTR_W     = 16;
  localparam int          INDEX_W     = 32;
  localparam int          BUF_DEPTH   = 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INDEX_W-1:0] pc;
  } buf_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc} between the cache response and decode.
// Handshake: the head is offered while head_valid=1 and leaves when the
// consumer asserts pop in the same cycle; push/pop may coincide; flush
// empties the FIFO after any same-cycle pop has been honoured.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [INDEX_W-1:0] push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [INDEX_W-1:0] head_pc,
  output logic [1:0]         count
);

  buf_entry_t ent_q [BUF_DEPTH];
  buf_entry_t ent_d [BUF_DEPTH];
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr;
  logic       do_pop;

  assign do_pop = pop && (count_q != 2'd0);
  // Write slot sits one past the head when the FIFO is not empty.
  assign wr_ptr = rd_ptr_q ^ (count_q != 2'd0);

  // Next-state for storage, read pointer and occupancy.
  always_comb begin
    ent_d    = ent_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        ent_d[wr_ptr] = '{instr: push_instr, pc: push_pc};
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head presentation: zeros whenever the FIFO is empty.
  always_comb begin
    head_valid = (count_q != 2'd0);
    head_instr = '0;
    head_pc    = '0;
    if (count_q != 2'd0) begin
      head_instr = ent_q[rd_ptr_q].instr;
      head_pc    = ent_q[rd_ptr_q].pc;
    end
  end

  assign count = count_q;

  // The upstream credit scheme must never deliver into a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !flush && (count_q == 2'd2)))
    else $error("fetch_buffer: push while full");

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the pc, issues registered cache requests,
// captures the response one cycle later into a 2-entry buffer and offers it
// to decode. Handles branch redirects, download halts and range faults.
// Decode handshake: instr/instr_pc are offered while instr_valid=1, held
// stable until instr_ready=1 in the same cycle, which transfers the head.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = cpu_pkg::RESET_PC,
  parameter int unsigned CACHE_WORDS = cpu_pkg::CACHE_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic [31:0] cache_index,
  output logic        cache_not_enable,
  input  logic [15:0] cache_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cache_index_q, cache_index_d;
  logic         cache_not_enable_q, cache_not_enable_d;
  logic         inflight_q, inflight_d;
  logic         fault_q, fault_d;

  logic         issue;
  logic         fault_set;
  logic         pop;
  logic         push;
  logic [1:0]   buf_count;
  logic [2:0]   occ_eff;
  logic         credit_ok;

  assign pop  = instr_valid && instr_ready;
  // A response returning in a branch cycle belongs to the abandoned path.
  assign push = inflight_q && !branch_valid;

  // Occupancy counts the entry leaving this cycle as already free so a
  // steady stream keeps one request per cycle with only two slots.
  assign occ_eff   = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok = (occ_eff < 3'd2);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // FSM next state: branch overrides everything, halt wins over a fault.
  always_comb begin
    state_d = state_q;
    if (branch_valid) begin
      state_d = halt ? HALT : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (halt)           state_d = HALT;
          else if (fault_set) state_d = FAULT;
        end
        HALT:    if (!halt) state_d = FETCH;
        FAULT:   state_d = FAULT;
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM outputs: decide whether a request issues or a fault is raised.
  always_comb begin
    issue     = 1'b0;
    fault_set = 1'b0;
    if (!branch_valid && (state_q == FETCH) && !halt && credit_ok) begin
      if (pc_q >= CACHE_WORDS) fault_set = 1'b1;
      else                     issue     = 1'b1;
    end
  end

  // Datapath next values: pc, registered cache request, sticky fault.
  always_comb begin
    pc_d               = pc_q;
    cache_index_d      = cache_index_q;
    cache_not_enable_d = ~issue;
    inflight_d         = issue;
    fault_d            = fault_q | fault_set;
    if (branch_valid) begin
      pc_d    = branch_target;
      fault_d = 1'b0;
    end else if (issue) begin
      pc_d          = pc_q + 32'd1;
      cache_index_d = pc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q               <= RESET_PC;
      cache_index_q      <= 32'd0;
      cache_not_enable_q <= 1'b1;
      inflight_q         <= 1'b0;
      fault_q            <= 1'b0;
    end else begin
      pc_q               <= pc_d;
      cache_index_q      <= cache_index_d;
      cache_not_enable_q <= cache_not_enable_d;
      inflight_q         <= inflight_d;
      fault_q            <= fault_d;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_instr (cache_data),
    .push_pc    (cache_index_q),
    .pop        (pop),
    .flush      (branch_valid),
    .head_valid (instr_valid),
    .head_instr (instr),
    .head_pc    (instr_pc),
    .count      (buf_count)
  );

  assign cache_index      = cache_index_q;
  assign cache_not_enable = cache_not_enable_q;
  assign fetch_fault      = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a cache model answers requests, a stream model of
// the program (sequential words from the last reset/branch target up to the
// end of the cache) fills the expected queue, and a monitor compares every
// instruction decode accepts.
module tb_ifetch_unit;

  localparam int          CW  = 1000;
  localparam logic [31:0] RPC = 32'd10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] cache_index;
  logic        cache_not_enable;
  logic [15:0] cache_data;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;

  logic [15:0] mem [CW];
  logic [47:0] exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  logic        halt_at_edge = 1'b0;
  logic        br_at_edge = 1'b0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_head = '0;

  // Clock and reset block.
  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RPC), .CACHE_WORDS(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .halt             (halt),
    .cache_index      (cache_index),
    .cache_not_enable (cache_not_enable),
    .cache_data       (cache_data),
    .branch_valid     (branch_valid),
    .branch_target    (branch_target),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .fetch_fault      (fetch_fault)
  );

  // Cache: data for the registered request is on the bus during the
  // cycle after the request was issued.
  assign cache_data = (!cache_not_enable && (cache_index < CW)) ? mem[cache_index] : 16'hDEAD;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Program-order model: after a redirect the next accepted instructions
  // are mem[t], mem[t+1], ... up to the last valid cache word.
  task automatic load_stream(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < CW; i++) begin
      if (i >= int'(t)) exp_q.push_back({mem[i], 32'(i)});
    end
  endtask

  // Driver: reset with latency checks; returns at posedge+1 after the
  // cycle in which the first instruction must be visible.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {47'd0, instr_valid}, 48'd0);
    check("rst_nen", {47'd0, cache_not_enable}, 48'd1);
    check("rst_index", {16'd0, cache_index}, 48'd0);
    check("rst_head", {instr, instr_pc}, 48'd0);
    check("rst_fault", {47'd0, fetch_fault}, 48'd0);
    load_stream(RPC);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("lat1_valid", {47'd0, instr_valid}, 48'd0);
    check("lat1_req", {15'd0, cache_not_enable, cache_index}, {16'd0, RPC});
    @(posedge clk);
    #1;
    check("lat2_head", {15'd0, instr_valid, instr_pc}, {16'd1, RPC});
  endtask

  // Driver: one-cycle redirect, called at posedge+1.
  task automatic do_branch(input logic [31:0] t);
    branch_target = t;
    branch_valid  = 1'b1;
    @(posedge clk);
    #1;
    branch_valid = 1'b0;
    load_stream(t);
  endtask

  always @(posedge clk) begin
    halt_at_edge <= halt;
    br_at_edge   <= branch_valid;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (instr_valid && instr_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_instr: got %h@%0d expected none", instr, instr_pc);
        end else begin
          vectors--;
          check("instr", {instr, instr_pc}, exp_q.pop_front());
        end
      end
      if (!instr_valid) check("empty_zero", {instr, instr_pc}, 48'd0);
      if (prev_stall && instr_valid) check("hold", {instr, instr_pc}, prev_head);
      if (!cache_not_enable) check("req_range", {47'd0, cache_index < CW}, 48'd1);
      if (halt_at_edge || br_at_edge) check("no_req", {47'd0, cache_not_enable}, 48'd1);
      prev_stall = instr_valid && !instr_ready;
      prev_head  = {instr, instr_pc};
    end
  end

  initial begin
    int halt_left;
    logic [31:0] tgt;
    for (int i = 0; i < CW; i++) mem[i] = 16'($urandom);
    mem[10] = 16'h0123;
    mem[11] = 16'h4567;
    mem[12] = 16'h89AB;
    mem[13] = 16'hCDEF;

    // Straight-line stream, one instruction per cycle.
    instr_ready = 1'b1;
    do_reset();
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("stream_pc", {15'd0, instr_valid, instr_pc}, {16'd1, RPC + 32'(k)});
    end
    repeat (4) @(posedge clk);
    #1;

    // Decode stalled: two entries buffered, requests stop.
    instr_ready = 1'b0;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("stall_head", {instr, instr_pc}, {16'h0123, RPC});
    check("stall_nen", {47'd0, cache_not_enable}, 48'd1);
    instr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Branch to 12 while the request for 11 is in flight.
    instr_ready = 1'b1;
    do_reset();
    do_branch(32'd12);
    repeat (3) @(posedge clk);
    #1;

    // Halt mid-stream.
    halt = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    halt = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Running off the end of the cache.
    do_branch(32'd998);
    repeat (8) @(posedge clk);
    #1;
    check("fault_set", {46'd0, fetch_fault, instr_valid}, {46'd0, 1'b1, 1'b0});
    check("fault_drained", 48'(exp_q.size()), 48'd0);
    do_branch(32'd10);
    check("fault_clear", {47'd0, fetch_fault}, 48'd0);
    repeat (2) @(posedge clk);
    #1;
    check("post_fault_head", {instr, instr_pc}, {16'h0123, 32'd10});
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with two entries buffered.
    instr_ready = 1'b0;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", {47'd0, instr_valid}, 48'd0);
    check("async_nen", {47'd0, cache_not_enable}, 48'd1);
    instr_ready = 1'b1;
    do_reset();

    // Randomized traffic: ready jitter, halt bursts, redirects.
    halt_left = 0;
    for (int c = 0; c < 400; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if (halt_left > 0) begin
        halt_left--;
        if (halt_left == 0) halt = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        halt = 1'b1;
        halt_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 24) == 0) begin
        tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(992, 999))
                                          : 32'($urandom_range(0, 990));
        do_branch(tgt);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    halt = 1'b0;
    instr_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
